// File: rtl/adder_pkg.sv
// Shared types and constants for the serial word adder and its 2-bit slice.
package adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam int unsigned SLICE_BITS = 2;

   // Slice-counter width for a given operand width, never narrower than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      int unsigned w;
      w = $clog2(width / SLICE_BITS);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/two_bit_adder.sv
// Combinational 2-bit adder slice with carry in/out.
module two_bit_adder (
   input  logic [1:0] A,
   input  logic [1:0] B,
   input  logic       CarryIN,
   output logic [1:0] Sum,
   output logic       CarryOUT
);

   assign {CarryOUT, Sum} = {1'b0, A} + {1'b0, B} + {2'b00, CarryIN};

endmodule

// File: rtl/serial_word_adder.sv
// Adds two WIDTH-bit operands 2 bits per clock through one two_bit_adder slice.
// Optional macro SERIAL_ADDER_OVERFLOW_EN adds a registered two's-complement Overflow output.
module serial_word_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CarryIN,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Sum,
   output logic             CarryOUT
`ifdef SERIAL_ADDER_OVERFLOW_EN
   ,
   output logic             Overflow
`endif
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);
   localparam int unsigned LAST  = WIDTH / SLICE_BITS - 1;

   generate
      if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
         $error("serial_word_adder: WIDTH must be even and at least 2");
      end
   endgenerate

   state_t            r_state;
   logic              r_in_ready;
   logic              r_out_valid;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic              r_carry;
   logic [CNT_W-1:0]  r_cnt;
   logic [WIDTH-1:0]  r_sum;
   logic              r_cout;

   logic [1:0]        w_slice_sum;
   logic              w_slice_cout;
   logic [WIDTH-1:0]  w_sum_next;
   logic              w_last;

   two_bit_adder u_slice (
      .A        (r_a[1:0]),
      .B        (r_b[1:0]),
      .CarryIN  (r_carry),
      .Sum      (w_slice_sum),
      .CarryOUT (w_slice_cout)
   );

   // New slice result enters from the top so the LSB slice ends at bit 0.
   generate
      if (WIDTH == 2) begin : g_sum_w2
         assign w_sum_next = w_slice_sum;
      end else begin : g_sum_wn
         assign w_sum_next = {w_slice_sum, r_sum[WIDTH-1:2]};
      end
   endgenerate

   assign w_last = (r_cnt == CNT_W'(LAST));

`ifdef SERIAL_ADDER_OVERFLOW_EN
   logic r_a_msb;
   logic r_b_msb;
   logic r_ovf;
   assign Overflow = r_ovf;
`endif

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
         r_a_msb     <= 1'b0;
         r_b_msb     <= 1'b0;
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (InValid && r_in_ready) begin
                  r_a        <= A;
                  r_b        <= B;
                  r_carry    <= CarryIN;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_RUN;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                  r_a_msb    <= A[WIDTH-1];
                  r_b_msb    <= B[WIDTH-1];
`endif
               end
            end
            ST_RUN: begin
               r_sum   <= w_sum_next;
               r_carry <= w_slice_cout;
               r_a     <= r_a >> SLICE_BITS;
               r_b     <= r_b >> SLICE_BITS;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_cout      <= w_slice_cout;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_HOLD;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                  r_ovf       <= (r_a_msb == r_b_msb) && (w_slice_sum[1] != r_a_msb);
`endif
               end
            end
            ST_HOLD: begin
               if (r_out_valid && OutReady) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign InReady  = r_in_ready;
   assign OutValid = r_out_valid;
   assign Sum      = r_sum;
   assign CarryOUT = r_cout;

endmodule

// File: tb/tb_serial_word_adder.sv
// Directed self-checking bench for serial_word_adder (WIDTH=8 and WIDTH=2 instances).
`timescale 1ns/1ps
module tb_serial_word_adder;

   logic       Clock;
   logic       Reset;

   logic       d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready, d8_cin, d8_cout;
   logic [7:0] d8_a, d8_b, d8_sum;
   logic       d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_cin, d2_cout;
   logic [1:0] d2_a, d2_b, d2_sum;
`ifdef SERIAL_ADDER_OVERFLOW_EN
   logic       d8_ovf, d2_ovf;
`endif

   int vectors     = 0;
   int miscompares = 0;

   serial_word_adder #(.WIDTH(8)) dut8 (
      .Clock    (Clock),
      .Reset    (Reset),
      .InValid  (d8_in_valid),
      .InReady  (d8_in_ready),
      .A        (d8_a),
      .B        (d8_b),
      .CarryIN  (d8_cin),
      .OutValid (d8_out_valid),
      .OutReady (d8_out_ready),
      .Sum      (d8_sum),
      .CarryOUT (d8_cout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ,
      .Overflow (d8_ovf)
`endif
   );

   serial_word_adder #(.WIDTH(2)) dut2 (
      .Clock    (Clock),
      .Reset    (Reset),
      .InValid  (d2_in_valid),
      .InReady  (d2_in_ready),
      .A        (d2_a),
      .B        (d2_b),
      .CarryIN  (d2_cin),
      .OutValid (d2_out_valid),
      .OutReady (d2_out_ready),
      .Sum      (d2_sum),
      .CarryOUT (d2_cout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ,
      .Overflow (d2_ovf)
`endif
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present operands at a falling edge; they are captured on the next rising edge.
   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin);
      chk("accept_ready", 32'(d8_in_ready), 32'd1);
      d8_in_valid = 1'b1;
      d8_a = a;
      d8_b = b;
      d8_cin = cin;
      @(negedge Clock);
      d8_in_valid = 1'b0;
      d8_a = 8'($urandom);
      d8_b = 8'($urandom);
      d8_cin = 1'($urandom);
   endtask

   task automatic wait_valid8(input string tag);
      int n;
      n = 0;
      while (!d8_out_valid && n < 12) begin
         @(negedge Clock);
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'd4);
   endtask

   task automatic take8();
      d8_out_ready = 1'b1;
      @(negedge Clock);
      d8_out_ready = 1'b0;
      chk("handoff_valid", 32'(d8_out_valid), 32'd0);
      chk("handoff_ready", 32'(d8_in_ready), 32'd1);
   endtask

   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [7:0] es, input logic ec, input logic eo);
      send8(a, b, cin);
      wait_valid8(tag);
      chk({tag, "_sum"}, 32'(d8_sum), 32'(es));
      chk({tag, "_cout"}, 32'(d8_cout), 32'(ec));
      chk({tag, "_hold_inready"}, 32'(d8_in_ready), 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
      chk({tag, "_ovf"}, 32'(d8_ovf), 32'(eo));
`else
      if (eo === 1'bx) $display("note: unexpected overflow argument");
`endif
      take8();
   endtask

   initial begin
      Reset = 1'b1;
      d8_in_valid = 1'b0; d8_out_ready = 1'b0; d8_a = '0; d8_b = '0; d8_cin = 1'b0;
      d2_in_valid = 1'b0; d2_out_ready = 1'b1; d2_a = '0; d2_b = '0; d2_cin = 1'b0;

      repeat (2) @(negedge Clock);
      chk("rst_inready", 32'(d8_in_ready), 32'd1);
      chk("rst_outvalid", 32'(d8_out_valid), 32'd0);
      chk("rst_sum", 32'(d8_sum), 32'd0);
      chk("rst_cout", 32'(d8_cout), 32'd0);
      Reset = 1'b0;

      // 0F + 01 with a held-off consumer: outputs must stay frozen.
      send8(8'h0F, 8'h01, 1'b0);
      wait_valid8("t0f");
      chk("t0f_sum", 32'(d8_sum), 32'h10);
      chk("t0f_cout", 32'(d8_cout), 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge Clock);
         chk("stall_valid", 32'(d8_out_valid), 32'd1);
         chk("stall_sum", 32'(d8_sum), 32'h10);
         chk("stall_cout", 32'(d8_cout), 32'd0);
         chk("stall_inready", 32'(d8_in_ready), 32'd0);
      end
      take8();
      chk("held_sum", 32'(d8_sum), 32'h10);

      run8("ripple", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
      run8("c3c", 8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1, 1'b0);
      run8("mix", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

      // Reset two cycles into RUN discards the partial result.
      send8(8'hAA, 8'h55, 1'b0);
      repeat (2) @(negedge Clock);
      Reset = 1'b1;
      #1;
      chk("midrst_inready", 32'(d8_in_ready), 32'd1);
      chk("midrst_valid", 32'(d8_out_valid), 32'd0);
      chk("midrst_sum", 32'(d8_sum), 32'd0);
      chk("midrst_cout", 32'(d8_cout), 32'd0);
      @(negedge Clock);
      Reset = 1'b0;
      chk("postrst_valid", 32'(d8_out_valid), 32'd0);
      run8("one_one", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

      run8("ovf_7f", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      run8("ovf_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      run8("ovf_10", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

      // WIDTH=2 exhaustive: one accepted operand set every 3 cycles.
      for (int i = 0; i < 32; i++) begin
         logic [4:0] v;
         logic [2:0] exp3;
         v = 5'(i);
         exp3 = {1'b0, v[4:3]} + {1'b0, v[2:1]} + {2'b00, v[0]};
         chk("w2_inready", 32'(d2_in_ready), 32'd1);
         d2_in_valid = 1'b1;
         d2_a = v[4:3];
         d2_b = v[2:1];
         d2_cin = v[0];
         @(negedge Clock);
         d2_in_valid = 1'b0;
         chk("w2_run_valid", 32'(d2_out_valid), 32'd0);
         @(negedge Clock);
         chk("w2_valid", 32'(d2_out_valid), 32'd1);
         chk("w2_result", 32'({d2_cout, d2_sum}), 32'(exp3));
         @(negedge Clock);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
